// File: rtl/down_counter.sv
// Loadable down counter / countdown timer with prescaler and one-cycle done pulse at terminal count.
// Define DOWN_COUNTER_RELOAD_EN for periodic mode (terminal step reloads the last load value).
module down_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             adv, step;
`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign adv  = (state_q == COUNT) && enable;
  assign step = adv && (presc_q == PS_LAST);

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      out_d   = load_value;
      presc_d = '0;
      state_d = (load_value != '0) ? COUNT : IDLE;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_d = load_value;
`endif
    end else if (adv) begin
      presc_d = step ? '0 : presc_q + PW'(1);
      if (step) begin
        if (out_q > WIDTH'(1)) begin
          out_d = out_q - WIDTH'(1);
        end else begin
          // Terminal step: never wrap below zero.
          done_d = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
          out_d   = reload_q;
`else
          out_d   = '0;
          state_d = IDLE;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      out_q    <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
`ifdef DOWN_COUNTER_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign out  = out_q;
  assign busy = (state_q == COUNT);
  assign done = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: two instances (PRESCALE 1 and 4) sharing stimulus, directed tasks plus a random run
// against a per-instance behavioural model.
module tb_down_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load, enable;
  logic [7:0] load_value;
  logic [7:0] out1, out4;
  logic       busy1, busy4, done1, done4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .enable(enable), .out(out1), .busy(busy1), .done(done1));

  down_counter #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .enable(enable), .out(out4), .busy(busy4), .done(done4));

  // Reference: value, enabled cycles since the last step, running flag, pulse.
  int m_out[2], m_rel[2], m_ph[2];
  bit m_busy[2], m_done[2];

  function automatic int ps(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_out[k] = 0; m_rel[k] = 0; m_ph[k] = 0; m_busy[k] = 0; m_done[k] = 0;
      end else begin
        m_done[k] = 0;
        if (load) begin
          m_out[k] = load_value; m_rel[k] = load_value; m_ph[k] = 0;
          m_busy[k] = (load_value != 0);
        end else if (m_busy[k] && enable) begin
          m_ph[k] = m_ph[k] + 1;
          if (m_ph[k] == ps(k)) begin
            m_ph[k] = 0;
            if (m_out[k] == 1) begin
              m_done[k] = 1;
`ifdef DOWN_COUNTER_RELOAD_EN
              m_out[k] = m_rel[k];
`else
              m_out[k] = 0;
              m_busy[k] = 0;
`endif
            end else begin
              m_out[k] = m_out[k] - 1;
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    bit saw_done;
    reset_n = 1'b0; load = 1'b0; enable = 1'b0; load_value = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (out1 !== 8'd0) begin errors++; $display("FAIL reset_out1 got=%0d exp=0", out1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1 got=%b exp=0", done1); end
    checks++; if (out4 !== 8'd0 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_dut4 got out=%0d busy=%b exp 0/0", out4, busy4); end
    reset_n = 1'b1;
    @(negedge clk);
    load = 1'b1; load_value = 8'd5; enable = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out1 !== 8'd0) begin errors++; $display("FAIL async_reset_out got=%0d exp=0", out1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL async_reset_done got=%b exp=0", done1); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done1 || done4) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL post_reset_no_done got=%b exp=0", saw_done); end
  endtask

`ifndef DOWN_COUNTER_RELOAD_EN
  task automatic test_one_shot();
    int exp;
    load = 1'b1; load_value = 8'd3; enable = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++; if (out1 !== 8'd3 || busy1 !== 1'b1 || done1 !== 1'b0)
      begin errors++; $display("FAIL oneshot_load got out=%0d busy=%b done=%b exp 3/1/0", out1, busy1, done1); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      exp = 3 - i;
      checks++; if (out1 !== 8'(exp) || done1 !== (exp == 0) || busy1 !== (exp != 0))
        begin errors++; $display("FAIL oneshot_step%0d got out=%0d busy=%b done=%b exp out=%0d", i, out1, busy1, done1, exp); end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out1 !== 8'd0 || done1 !== 1'b0)
        begin errors++; $display("FAIL oneshot_hold%0d got out=%0d done=%b exp 0/0", i, out1, done1); end
    end
  endtask
`else
  task automatic test_reload();
    int exp;
    load = 1'b1; load_value = 8'd4; enable = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp = (c % 4 == 0) ? 4 : 4 - (c % 4);
      checks++; if (out1 !== 8'(exp) || done1 !== (c % 4 == 0) || busy1 !== 1'b1)
        begin errors++; $display("FAIL reload_c%0d got out=%0d busy=%b done=%b exp out=%0d", c, out1, busy1, done1, exp); end
    end
  endtask
`endif

  task automatic test_prescale_pause();
    int cyc;
    load = 1'b1; load_value = 8'd0; enable = 1'b1;
    @(negedge clk);
    load_value = 8'd2;
    @(negedge clk);
    load = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      if (cyc == 3) enable = 1'b0;
      if (cyc == 6) enable = 1'b1;
      @(negedge clk);
      cyc++;
      if (done4) break;
    end
    checks++; if (cyc !== 11) begin errors++; $display("FAIL prescale_pause_latency got=%0d exp=11", cyc); end
    @(negedge clk);
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL prescale_done_width got=%b exp=0", done4); end
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_value = 8'd3; enable = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out1 !== 8'd1) begin errors++; $display("FAIL prio_setup got=%0d exp=1", out1); end
    load = 1'b1; load_value = 8'd7;
    @(negedge clk);
    load = 1'b0;
    checks++; if (out1 !== 8'd7) begin errors++; $display("FAIL prio_out got=%0d exp=7", out1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL prio_done got=%b exp=0", done1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL prio_busy got=%b exp=1", busy1); end
  endtask

  task automatic test_load_zero();
    load = 1'b1; load_value = 8'd5; enable = 1'b1;
    @(negedge clk);
    load_value = 8'd0;
    @(negedge clk);
    load = 1'b0;
    checks++; if (out1 !== 8'd0 || busy1 !== 1'b0 || done1 !== 1'b0)
      begin errors++; $display("FAIL load0_dut1 got out=%0d busy=%b done=%b exp 0/0/0", out1, busy1, done1); end
    checks++; if (out4 !== 8'd0 || busy4 !== 1'b0 || done4 !== 1'b0)
      begin errors++; $display("FAIL load0_dut4 got out=%0d busy=%b done=%b exp 0/0/0", out4, busy4, done4); end
  endtask

  task automatic test_full_range();
    int cyc, bad;
    load = 1'b1; load_value = 8'd255; enable = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cyc = 0; bad = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done1) break;
      if (out1 !== 8'(255 - cyc)) bad++;
    end
    checks++; if (cyc !== 255) begin errors++; $display("FAIL full_range_latency got=%0d exp=255", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_range_sequence got=%0d bad steps exp=0", bad); end
`ifdef DOWN_COUNTER_RELOAD_EN
    checks++; if (out1 !== 8'd255) begin errors++; $display("FAIL full_range_terminal got=%0d exp=255", out1); end
`else
    @(negedge clk);
    checks++; if (out1 !== 8'd0) begin errors++; $display("FAIL full_range_no_wrap got=%0d exp=0", out1); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] ao;
    logic       ab, ad;
    for (int n = 0; n < 400; n++) begin
      load       = ($urandom_range(0, 12) == 0);
      load_value = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      enable     = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ao = (k == 0) ? out1 : out4;
        ab = (k == 0) ? busy1 : busy4;
        ad = (k == 0) ? done1 : done4;
        checks++; if (ao !== 8'(m_out[k])) begin errors++; $display("FAIL rand_out k=%0d n=%0d got=%0d exp=%0d", k, n, ao, m_out[k]); end
        checks++; if (ab !== m_busy[k]) begin errors++; $display("FAIL rand_busy k=%0d n=%0d got=%b exp=%b", k, n, ab, m_busy[k]); end
        checks++; if (ad !== m_done[k]) begin errors++; $display("FAIL rand_done k=%0d n=%0d got=%b exp=%b", k, n, ad, m_done[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef DOWN_COUNTER_RELOAD_EN
    test_one_shot();
`else
    test_reload();
`endif
    test_prescale_pause();
    test_load_priority();
    test_load_zero();
    test_full_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable down counter / countdown timer: the decrementing counterpart to the team's 8-bit up counter. It is loaded with a start value, counts down one step per enabled prescaled tick, and flags terminal count with a one-cycle `done` pulse. It sits beside the up counter in the demo design as the timeout/interval generator for control logic.

## Interface
- `WIDTH`, 8: counter and load-value width in bits (≥ 2).
- `PRESCALE`, 1: number of enabled clock cycles per decrement step (≥ 1). A value of 1 means decrement on every enabled cycle.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `load` in 1: synchronous load strobe, sampled each cycle.
- `load_value` in `WIDTH`: start value, captured when `load`=1.
- `enable` in 1: count enable. When low, the counter pauses and holds `out` and the prescaler.
- `out` out `WIDTH`: current count (registered).
- `busy` out 1: high while the state is COUNT.
- `done` out 1: one-cycle pulse at terminal count.

## Operation
- State machine:
  - IDLE: `busy`=0; `out` holds; `enable` is ignored.
  - COUNT: `busy`=1.
- Prescaler: a counter of width clog2(`PRESCALE`), minimum 1 bit.
  - Advances only in COUNT with `enable`=1.
  - A step occurs when the prescaler equals `PRESCALE`-1; the prescaler then returns to 0.
- Load (highest priority, accepted in any state):
  - `out` <= `load_value`; `reload_reg` <= `load_value`; prescaler <= 0.
  - Next state is COUNT if `load_value`≠0, otherwise IDLE.
  - A load never produces `done`.
- Step in COUNT:
  - If `out`>1: `out` <= `out`-1.
  - If `out`==1 (terminal step): `out` <= 0, `done` <= 1 for exactly one cycle, next state IDLE (see Configuration for reload behaviour).
- Underflow: `out` never decrements below 0 and never wraps to all-ones. IDLE at 0 stays at 0 until the next load.
- Simultaneous events:
  - `load` together with a terminal step: the load wins and `done` stays 0.
  - `load` together with `enable`=0: the load still takes effect.
- `load_value` is only sampled when `load`=1.
- Arithmetic is unsigned, modulo-free, `WIDTH` bits.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0, state IDLE, prescaler 0, `reload_reg`=0.
  - Reset is asynchronous on assertion.
  - Release is synchronous to `clk`, handled by the system reset synchronizer.
- Reset asserted mid-count returns every output to its reset value immediately; no `done` is emitted.
- Load latency: `out` shows `load_value` and `busy`=1 on the first edge after `load` is sampled.
- Decrement latency: `out` updates on the clock edge at which the step condition holds.
- `done` is registered and is high in the same cycle `out` first shows the terminal value.
- Count duration from load of N≠0 with `enable` held high: `done` rises N×`PRESCALE` cycles after the load edge.
- Deasserting `enable` stretches the duration by exactly the number of cycles it is low.

## Configuration
- `DOWN_COUNTER_RELOAD_EN` defined: periodic mode.
  - The terminal step sets `out` <= `reload_reg` instead of 0, pulses `done`, and stays in COUNT.
  - `busy` remains 1, giving a `done` pulse every `reload_reg`×`PRESCALE` enabled cycles until reset or until a load of 0.
- Not defined: one-shot mode as in Operation. `reload_reg` may be optimized away.

## Test plan
- Reset: assert `reset_n`=0 mid-count from 5 → `out`=0, `busy`=0, `done`=0 asynchronously; no `done` pulse afterwards.
- One-shot, `WIDTH`=8, `PRESCALE`=1:
  - Stimulus: load 3, `enable`=1.
  - Response: `out` 3,2,1,0 on successive edges; `done`=1 only in the cycle `out`=0; `busy` falls with it; `out` stays 0 for 10 further cycles.
- Pause and prescale, `PRESCALE`=4:
  - Stimulus: load 2; drop `enable` for 3 cycles midway.
  - Response: `done` exactly 11 cycles after the load edge.
- Load priority:
  - Stimulus: load 7 in the cycle `out`=1 with `enable`=1.
  - Response: `out`=7, `done` stays 0, `busy`=1.
- Load 0 → `out`=0, `busy`=0, no `done`. Load 255 → full-range count; `done` after 255 cycles with no wrap.
- With `DOWN_COUNTER_RELOAD_EN`:
  - Stimulus: load 4, `enable`=1 for 20 cycles.
  - Response: `done` pulses at cycles 4, 8, 12, 16, 20; `out` sequence 4,3,2,1,4,…; `busy` constant 1.
